// File: rtl/dda_pkg.sv
// ============================================================================
//  Module      : dda_pkg
//  Description : Shared constants, trace FSM state type and helpers for the
//                DDA solver and its trace capture block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dda_pkg;

    localparam int DW    = 9;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int DECW  = 16;

    // Q2.16 constants shared with the solver datapath
    localparam logic signed [17:0] Q_ONE  = 18'sh10000;
    localparam logic signed [17:0] Q_HALF = 18'sh08000;
    localparam logic signed [17:0] Q_ZERO = 18'sh00000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    // prev < 0 and cur >= 0 in two's complement reduces to the sign bits
    function automatic logic zero_cross_rise(input logic [DW-1:0] prev,
                                             input logic [DW-1:0] cur);
        return prev[DW-1] & ~cur[DW-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dda_trace_capture_if.sv
// ============================================================================
//  Module      : dda_trace_capture_if
//  Description : CPU/solver side bus of the trace capture block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dda_trace_capture_if;
    import dda_pkg::*;

    logic            clk_en;
    logic [DW-1:0]   x_shift;
    logic [DECW-1:0] decim;
    logic            arm;
    logic            abort;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            busy;
    logic            done;
    logic            irq;
    logic [AW:0]     sample_count;

    modport master (
        output clk_en, x_shift, decim, arm, abort, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, done, irq, sample_count
    );

    modport slave (
        input  clk_en, x_shift, decim, arm, abort, rd_en, rd_addr,
        output rd_data, rd_valid, busy, done, irq, sample_count
    );

endinterface

`default_nettype wire

// File: rtl/dda_trace_ram.sv
// ============================================================================
//  Module      : dda_trace_ram
//  Description : Simple dual-port trace RAM, one write port and one
//                registered read port (read-before-write on collision).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dda_trace_ram #(
    parameter int DW    = 9,
    parameter int AW    = 9,
    parameter int DEPTH = 512
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [DW-1:0] i_wr_data,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_rd_addr,
    output logic      [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // No reset on the array so it maps onto block RAM and survives reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/dda_trace_capture.sv
// ============================================================================
//  Module      : dda_trace_capture
//  Description : Decimated capture of the solver x_shift stream into a
//                software-readable trace buffer. Optional zero-crossing
//                trigger enabled by defining DDA_TRACE_TRIG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dda_trace_capture
    import dda_pkg::*;
(
    input  wire logic          clk0_020,
    input  wire logic          rst,
    dda_trace_capture_if.slave bus
);

    localparam logic [AW:0] C_LAST_COUNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    trace_state_t    r_state;
    trace_state_t    w_next;
    logic [DECW-1:0] r_decim;
    logic [DECW-1:0] r_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic            r_irq;
    logic            r_rd_valid;

    logic            w_start;
    logic            w_trig;
    logic            w_take;
    logic            w_we;
    logic            w_last;
    logic [AW-1:0]   w_wr_addr;

    assign w_start = bus.arm && !bus.abort && (r_state == IDLE || r_state == DONE);

`ifdef DDA_TRACE_TRIG_EN
    logic [DW-1:0] r_prev;
    logic          r_prev_valid;

    assign w_trig = (r_state == ARMED) && bus.clk_en && !bus.abort && r_prev_valid
                    && zero_cross_rise(r_prev, bus.x_shift);

    always_ff @(posedge clk0_020) begin
        if (!rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_start) begin
            r_prev_valid <= 1'b0;
        end else if (r_state == ARMED && bus.clk_en) begin
            r_prev       <= bus.x_shift;
            r_prev_valid <= 1'b1;
        end
    end
`else
    assign w_trig = 1'b0;
`endif

    assign w_take    = (r_state == CAPTURE) && bus.clk_en && !bus.abort && (r_cnt == '0);
    assign w_we      = w_take || w_trig;
    // The triggering sample always lands at the start of the buffer
    assign w_wr_addr = (r_state == ARMED) ? '0 : r_wr_ptr;
    assign w_last    = w_take && (r_count == C_LAST_COUNT);

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
`ifdef DDA_TRACE_TRIG_EN
                    if (bus.arm) w_next = ARMED;
`else
                    if (bus.arm) w_next = CAPTURE;
`endif
                end
                ARMED:   if (w_trig) w_next = CAPTURE;
                CAPTURE: if (w_last) w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk0_020) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_decim    <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_irq      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_irq      <= (r_state == CAPTURE) && (w_next == DONE);
            r_rd_valid <= bus.rd_en;
            if (w_start) begin
                r_decim  <= bus.decim;
                r_cnt    <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_we) begin
                r_cnt    <= r_decim;
                r_wr_ptr <= w_last ? r_wr_ptr : w_wr_addr + AW'(1);
                if (r_count != C_FULL_COUNT) begin
                    r_count <= r_count + (AW+1)'(1);
                end
            end else if (r_state == CAPTURE && bus.clk_en && !bus.abort) begin
                r_cnt <= r_cnt - DECW'(1);
            end
        end
    end

    dda_trace_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk0_020),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.x_shift),
        .i_re      (bus.rd_en),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (bus.rd_data)
    );

    assign bus.rd_valid     = r_rd_valid;
    assign bus.busy         = (r_state == ARMED) || (r_state == CAPTURE);
    assign bus.done         = (r_state == DONE);
    assign bus.irq          = r_irq;
    assign bus.sample_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dda_trace_capture.sv
// ============================================================================
//  Module      : tb_dda_trace_capture
//  Description : Randomized scoreboard bench for dda_trace_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dda_trace_capture;
    import dda_pkg::*;

`ifdef DDA_TRACE_TRIG_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dda_trace_capture_if u_if ();

    dda_trace_capture u_dut (
        .clk0_020 (clk),
        .rst      (rst_n),
        .bus      (u_if)
    );

    // Reference model: trace as an array, capture as "every (D+1)-th enabled sample"
    int            m_mode = M_IDLE;
    int            m_n = 0, m_k = 0, m_d = 0, m_hi = 0;
    bit            m_irq = 1'b0;
    bit            m_prevv = 1'b0;
    logic signed [DW-1:0] m_prev = '0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void store(input logic [DW-1:0] x);
        m_mem[m_n] = x;
        m_n++;
        if (m_n > m_hi) m_hi = m_n;
    endfunction

    function automatic void model_step();
        logic signed [DW-1:0] x;
        x = $signed(u_if.x_shift);
        m_irq = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_n    = 0;
        end else begin
            if (u_if.rd_en) exp_q.push_back(m_mem[u_if.rd_addr]);
            if (u_if.abort) begin
                m_mode = M_IDLE;
            end else if (u_if.arm && (m_mode == M_IDLE || m_mode == M_DONE)) begin
                m_mode  = TRIG ? M_ARMED : M_CAP;
                m_n     = 0;
                m_k     = 0;
                m_d     = int'(u_if.decim);
                m_prevv = 1'b0;
            end else if (u_if.clk_en && m_mode == M_CAP) begin
                if (m_k % (m_d + 1) == 0) begin
                    store(u_if.x_shift);
                    if (m_n == DEPTH) begin
                        m_mode = M_DONE;
                        m_irq  = 1'b1;
                    end
                end
                m_k++;
            end else if (u_if.clk_en && m_mode == M_ARMED) begin
                if (m_prevv && m_prev < 0 && x >= 0) begin
                    store(u_if.x_shift);
                    m_k    = 1;
                    m_mode = M_CAP;
                end else begin
                    m_prev  = x;
                    m_prevv = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("busy", int'(u_if.busy), int'(m_mode == M_ARMED || m_mode == M_CAP));
        check("done", int'(u_if.done), int'(m_mode == M_DONE));
        check("irq", int'(u_if.irq), int'(m_irq));
        check("sample_count", int'(u_if.sample_count), m_n);
    endtask

    // Scoreboard monitor: pops one expected word per rd_valid
    always @(negedge clk) begin
        if (u_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no read pending");
            end else begin
                check("rd_data", int'(u_if.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic pulse_arm(input int d, input bit with_abort);
        u_if.decim = DECW'(d);
        u_if.arm   = 1'b1;
        u_if.abort = with_abort;
        tick();
        u_if.arm   = 1'b0;
        u_if.abort = 1'b0;
    endtask

    task automatic pulse_abort();
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
    endtask

    task automatic read_one(input int a);
        u_if.rd_en   = 1'b1;
        u_if.rd_addr = AW'(a);
        tick();
        u_if.rd_en   = 1'b0;
    endtask

    // en_mode: 0 always, 1 toggling, 2 random; x_mode: 0 ramp, 1 random
    task automatic run(input int cycles, input int en_mode, input int x_mode,
                       input bit rd, input int stop_n);
        for (int i = 0; i < cycles; i++) begin
            case (en_mode)
                0:       u_if.clk_en = 1'b1;
                1:       u_if.clk_en = (i % 2 == 0);
                default: u_if.clk_en = 1'($urandom);
            endcase
            u_if.x_shift = (x_mode == 0) ? DW'(i) : DW'($urandom);
            if (rd && m_hi > 0 && $urandom_range(0, 2) == 0) begin
                u_if.rd_en   = 1'b1;
                u_if.rd_addr = AW'($urandom_range(0, m_hi - 1));
            end else begin
                u_if.rd_en = 1'b0;
            end
            tick();
            if (m_mode == M_DONE || m_n >= stop_n) break;
        end
        u_if.rd_en  = 1'b0;
        u_if.clk_en = 1'b0;
    endtask

    initial begin
        u_if.clk_en  = 1'b0;
        u_if.x_shift = '0;
        u_if.decim   = '0;
        u_if.arm     = 1'b0;
        u_if.abort   = 1'b0;
        u_if.rd_en   = 1'b0;
        u_if.rd_addr = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_rd_data", int'(u_if.rd_data), 0);
        check("rst_rd_valid", int'(u_if.rd_valid), 0);
        rst_n = 1'b1;
        tick();

        // Decim 0, ramp input, every enabled cycle sampled, then full readback
        pulse_arm(0, 1'b0);
        run(2000, 0, 0, 1'b0, DEPTH + 1);
        check("t2_done_reached", m_mode, M_DONE);
        for (int a = 0; a < DEPTH; a++) read_one(a);
        tick();

        // Decim 3 with toggling clk_en, concurrent reads including address 7
        pulse_arm(3, 1'b0);
        run(200, 1, 1, 1'b1, DEPTH + 1);
        read_one(7);
        u_if.arm = 1'b1;          // ignored while capturing
        tick();
        u_if.arm = 1'b0;
        run(6000, 1, 1, 1'b1, DEPTH + 1);
        check("t3_full_count", int'(u_if.sample_count), DEPTH);

        // arm with abort in the same cycle stays idle
        pulse_abort();
        pulse_arm(2, 1'b1);
        check("t5_idle_busy", int'(u_if.busy), 0);

        // Abort at sample 100 keeps the count
        pulse_arm(0, 1'b0);
        run(1000, 0, 1, 1'b1, 100);
        pulse_abort();
        check("t5_abort_count", int'(u_if.sample_count), 100);
        run(20, 2, 1, 1'b1, DEPTH + 1);

        // Reset mid-capture, then partial buffer readback
        pulse_arm(1, 1'b0);
        run(150, 2, 1, 1'b1, DEPTH + 1);
        repeat (2) tick();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        check("t1_count_after_rst", int'(u_if.sample_count), 0);
        for (int a = 0; a < 8; a++) read_one(a);

        // Random decimation, random enables and data
        for (int r = 0; r < 3; r++) begin
            pulse_arm($urandom_range(0, 4), 1'b0);
            run(4000, 2, 1, 1'b1, DEPTH + 1);
        end

        if (TRIG) begin
            // Zero sample right after arm must not trigger; 5,-3,-1,0,4 triggers on 0
            int seq [6];
            seq = '{0, 5, -3, -1, 0, 4};
            pulse_arm(0, 1'b0);
            u_if.clk_en = 1'b1;
            foreach (seq[i]) begin
                u_if.x_shift = DW'(seq[i]);
                tick();
            end
            u_if.clk_en = 1'b0;
            check("t4_trig_count", int'(u_if.sample_count), 2);
            read_one(0);
            read_one(1);
            run(3000, 2, 1, 1'b1, DEPTH + 1);
        end

        repeat (3) tick();
        check("rd_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
